fb_pixel_writer: RTL and testbench

Upstream stage of the VGA pattern generator. It takes a byte stream of R,G,B triplets over a valid/ready handshake and packs them into 24-bit pixels. It writes each pixel into one bank of a double-buffered 192x108 framebuffer, and swaps the display bank at vertical sync. The generator reads the bank selected by `rd_bank`, so a new image appears tear-free on the frame after it is fully written.

---
 rtl/fb_pixel_writer.sv | 194 +++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//
// Front end of the VGA pattern generator. It accepts a byte stream of R,G,B
// triplets over a valid/ready handshake and packs every three bytes into one
// 24-bit pixel. Each pixel is written to the back bank of a double-buffered
// H_PIX x V_PIX framebuffer. When a frame is complete the block stalls the
// stream until the next vertical-sync falling edge. It then flips the banks,
// so the generator always displays a fully written image.
//
// Ports:
//   clk        in   pixel clock, shared with the generator
//   reset_n    in   asynchronous active-low reset
//   s_valid    in   byte-stream valid
//   s_data     in   8-bit byte, pixel order R, G, B
//   s_sof      in   start of frame, qualifies the R byte of pixel 0
//   s_ready    out  byte accepted this cycle when s_valid is also high
//   vga_vs     in   vertical sync from the generator (active low)
//   wr_en      out  framebuffer write strobe (one cycle per pixel)
//   wr_addr    out  linear pixel address row*H_PIX+col
//   wr_data    out  {R,G,B}
//   wr_bank    out  bank currently being written
//   rd_bank    out  bank currently being displayed
//   frame_done out  pulse coincident with the write of the last pixel
//   resync     out  pulse the cycle after an SOF arrives mid-frame

module fb_pixel_writer #(
  parameter int H_PIX  = 192,
  parameter int V_PIX  = 108,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              vga_vs,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              resync
);

  // Address of the final pixel. The running counter stops here, so it never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t            state_r;
  logic [1:0]        phase_r;       // 0 = expecting R, 1 = G, 2 = B
  logic [ADDR_W-1:0] addr_r;        // address of the pixel being assembled
  logic [7:0]        red_r;
  logic [7:0]        green_r;
  logic              vs_d_r;
  logic              ready_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [23:0]       wr_data_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic              frame_done_r;
  logic              resync_r;

  logic              xfer_s;
  logic              vs_fall_s;
  logic              last_pix_s;

  // Handshake qualifier, vsync falling-edge detect and last-pixel compare
  always_comb begin
    xfer_s     = s_valid && ready_r;
    vs_fall_s  = vs_d_r && !vga_vs;
    last_pix_s = (addr_r == LAST_ADDR);
  end

  assign s_ready    = ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_bank    = wr_bank_r;
  assign rd_bank    = rd_bank_r;
  assign frame_done = frame_done_r;
  assign resync     = resync_r;

  // Control FSM with pixel packing, address counter, bank swap and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      phase_r      <= 2'd0;
      addr_r       <= ADDR_ZERO;
      red_r        <= 8'h00;
      green_r      <= 8'h00;
      vs_d_r       <= 1'b1;
      ready_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= ADDR_ZERO;
      wr_data_r    <= 24'h000000;
      wr_bank_r    <= 1'b1;
      rd_bank_r    <= 1'b0;
      frame_done_r <= 1'b0;
      resync_r     <= 1'b0;
    end else begin
      vs_d_r       <= vga_vs;
      // Strobes default low and are raised for a single cycle below
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      resync_r     <= 1'b0;
      ready_r      <= 1'b1;

      case (state_r)
        IDLE: begin
          // Bytes that arrive before any SOF are accepted and discarded
          if (xfer_s && s_sof) begin
            red_r   <= s_data;
            phase_r <= 2'd1;
            addr_r  <= ADDR_ZERO;
            state_r <= FILL;
          end else begin
            state_r <= IDLE;
          end
        end

        FILL: begin
          if (xfer_s) begin
            if (s_sof) begin
              // An SOF at any byte position abandons the partial pixel and
              // restarts the frame in the same bank, using this byte as R
              resync_r <= 1'b1;
              red_r    <= s_data;
              phase_r  <= 2'd1;
              addr_r   <= ADDR_ZERO;
            end else begin
              case (phase_r)
                2'd0: begin
                  red_r   <= s_data;
                  phase_r <= 2'd1;
                end
                2'd1: begin
                  green_r <= s_data;
                  phase_r <= 2'd2;
                end
                2'd2: begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= addr_r;
                  wr_data_r <= {red_r, green_r, s_data};
                  phase_r   <= 2'd0;
                  if (last_pix_s) begin
                    // Frame complete. Stall the stream until the next vsync.
                    frame_done_r <= 1'b1;
                    ready_r      <= 1'b0;
                    state_r      <= WAIT_SWAP;
                  end else begin
                    addr_r <= addr_r + ADDR_ONE;
                  end
                end
                default: begin
                  phase_r <= 2'd0;
                end
              endcase
            end
          end else begin
            state_r <= FILL;
          end
        end

        WAIT_SWAP: begin
          // Flip the banks on a vsync falling edge. The freshly written bank
          // becomes the displayed one.
          if (vs_fall_s) begin
            rd_bank_r <= wr_bank_r;
            wr_bank_r <= ~wr_bank_r;
            state_r   <= IDLE;
          end else begin
            ready_r <= 1'b0;
          end
        end

        default: begin
          state_r <= IDLE;
          phase_r <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer. The framebuffer geometry is reduced
// (24 x 10) so that several complete frames fit in a short run. The frame
// boundary, bank swap and resync behaviour are unaffected by the geometry.

module tb_fb_pixel_writer;

  localparam int H    = 24;
  localparam int V    = 10;
  localparam int AW   = 15;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_sof;
  logic          s_ready;
  logic          vga_vs;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_bank;
  logic          rd_bank;
  logic          frame_done;
  logic          resync;

  fb_pixel_writer #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_sof(s_sof), .s_ready(s_ready), .vga_vs(vga_vs), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .frame_done(frame_done), .resync(resync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          bank;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   passes   = 0;
  int   fd_count = 0;
  int   rs_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: pop and compare whenever the DUT presents a write
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(wr_data), 32'(mon_e.data));
          chk("wr_bank", 32'(wr_bank), 32'(mon_e.bank));
          chk("frame_done_on_write", 32'(frame_done), 32'(mon_e.fd));
        end
      end else if (frame_done === 1'b1) begin
        chk("frame_done_without_write", 32'd1, 32'd0);
      end
      if (frame_done === 1'b1) fd_count++;
      if (resync === 1'b1) rs_count++;
    end
  end

  function automatic logic [23:0] pix(input int n);
    logic [15:0] v;
    v = n[15:0];
    return {v[7:0], v[15:8], 8'hA5};
  endfunction

  // Present one byte and return at the negedge that follows its transfer
  task automatic send_byte(input logic [7:0] d, input logic sof, input bit gaps);
    int budget;
    budget = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    while (s_ready !== 1'b1 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1000) chk("s_ready_timeout", 32'(budget), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_pixel(input int addr, input logic [23:0] d, input bit sof,
                            input bit gaps, input logic bank);
    exp_t e;
    e.addr = addr[AW-1:0];
    e.data = d;
    e.bank = bank;
    e.fd   = (addr == NPIX - 1);
    send_byte(d[23:16], sof, gaps);
    send_byte(d[15:8], 1'b0, gaps);
    exp_q.push_back(e);
    send_byte(d[7:0], 1'b0, gaps);
  endtask

  task automatic send_frame(input int first, input int last, input bit sof_first,
                            input bit gaps, input logic bank);
    for (int n = first; n <= last; n++)
      send_pixel(n, pix(n), sof_first && (n == first), gaps, bank);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Hold vsync high 100 cycles (block must stall), then drop it and check the swap
  task automatic vs_swap(input logic exp_rd, input logic exp_wr);
    bit ok;
    ok = 1'b1;
    vga_vs = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (s_ready !== 1'b0) ok = 1'b0;
    end
    chk("s_ready_low_in_wait", 32'(ok), 32'd1);
    vga_vs = 1'b0;
    @(negedge clk);
    chk("rd_bank_after_swap", 32'(rd_bank), 32'(exp_rd));
    chk("wr_bank_after_swap", 32'(wr_bank), 32'(exp_wr));
    chk("s_ready_after_swap", 32'(s_ready), 32'd1);
    vga_vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd1);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_resync"}, 32'(resync), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_sof   = 1'b0;
    vga_vs  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Frame 1: gapless, bank 1
    send_frame(0, NPIX - 1, 1'b1, 1'b0, 1'b1);
    drain();
    chk("frame_done_count_1", 32'(fd_count), 32'd1);
    vs_swap(1'b1, 1'b0);

    // 10 non-SOF bytes in IDLE are discarded, then a frame in bank 0
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    send_frame(0, NPIX - 1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("frame_done_count_2", 32'(fd_count), 32'd2);
    vs_swap(1'b0, 1'b1);

    // Mid-frame SOF after 40 pixels plus R and G bytes
    send_frame(0, 39, 1'b1, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0);
    send_pixel(0, 24'h112233, 1'b1, 1'b0, 1'b1);
    drain();
    chk("resync_count", 32'(rs_count), 32'd1);
    chk("wr_bank_after_resync", 32'(wr_bank), 32'd1);
    chk("rd_bank_after_resync", 32'(rd_bank), 32'd0);
    send_frame(1, NPIX - 1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("frame_done_count_3", 32'(fd_count), 32'd3);
    vs_swap(1'b1, 1'b0);

    // Reset in the middle of a bank-0 frame, with a partial pixel pending
    send_frame(0, 29, 1'b1, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_midframe_reset", 32'(s_ready), 32'd1);

    // Full frame with random valid gaps, starting from address 0 in bank 1
    send_frame(0, NPIX - 1, 1'b1, 1'b1, 1'b1);
    drain();
    chk("frame_done_count_final", 32'(fd_count), 32'd4);
    chk("resync_count_final", 32'(rs_count), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
